// File: rtl/encoder32_5_pend_pkg.sv
// Shared widths and the W->N one-hot decode used by the
// 32-to-5 pending-request encoder and its decoder twin.
package encoder32_5_pend_pkg;

  localparam int W = 5;
  localparam int N = 32;

  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/encoder32_5_pend_lsb_prio_enc.sv
// Combinational N->W encoder: index of the lowest set bit
// plus an any-set flag; mirror of the 5-to-32 decoder.
module lsb_prio_enc
  import encoder32_5_pend_pkg::*;
(
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
  end

endmodule

// File: rtl/encoder32_5_pend.sv
// Sequential 32-to-5 priority encoder: latches request pulses,
// presents the lowest pending index with a valid/ack handshake.
module encoder32_5_pend
  import encoder32_5_pend_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] L,
  input  logic         E,
  input  logic         A,
  output logic [W-1:0] B,
  output logic         V,
  output logic         O,
  output logic [W:0]   P
);

  function automatic logic [W:0] popcount(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
    return c;
  endfunction

  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] b_q, b_d;
  logic         v_q, v_d;
  logic         o_q, o_d;
  logic [W:0]   p_q, p_d;

  logic         acc;
  logic [N-1:0] clr, req, kept;
  logic [W-1:0] enc_idx;
  logic         enc_any;

  lsb_prio_enc u_enc (
    .vec_i (pend_d),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  always_comb begin
    acc    = v_q & A;
    clr    = acc ? onehot(b_q) : '0;
    req    = E ? L : '0;
    kept   = pend_q & ~clr;
    pend_d = kept | req;
    p_d    = popcount(pend_d);
    // A request hitting a still-pending line merges and is lost.
    o_d    = o_q | (|(req & kept));
    b_d    = b_q;
    v_d    = v_q;
    if (!v_q || acc) begin
      b_d = enc_idx;
      v_d = enc_any;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      b_q    <= '0;
      v_q    <= 1'b0;
      o_q    <= 1'b0;
      p_q    <= '0;
    end else begin
      pend_q <= pend_d;
      b_q    <= b_d;
      v_q    <= v_d;
      o_q    <= o_d;
      p_q    <= p_d;
    end
  end

  assign B = b_q;
  assign V = v_q;
  assign O = o_q;
  assign P = p_q;

endmodule

// File: tb/tb_encoder32_5_pend.sv
// Directed bench for encoder32_5_pend with an expectation queue.
module tb_encoder32_5_pend;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] L;
  logic        E;
  logic        A;
  logic [4:0]  B;
  logic        V;
  logic        O;
  logic [5:0]  P;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [4:0] b;
    logic       v;
    logic       o;
    logic [5:0] p;
  } exp_t;

  exp_t sb[$];

  encoder32_5_pend dut (
    .clk (clk),
    .rst (rst),
    .L   (L),
    .E   (E),
    .A   (A),
    .B   (B),
    .V   (V),
    .O   (O),
    .P   (P)
  );

  always #5 clk = ~clk;

  task automatic step(input string tag, input logic r,
                      input logic [31:0] l, input logic e,
                      input logic a, input logic [4:0] eb,
                      input logic ev, input logic eo,
                      input logic [5:0] ep);
    exp_t x;
    exp_t y;
    rst = r;
    L   = l;
    E   = e;
    A   = a;
    x.tag = tag;
    x.b = eb;
    x.v = ev;
    x.o = eo;
    x.p = ep;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    vectors++;
    assert (V === y.v) else begin
      miscompares++;
      $error("FAIL %s V got %b exp %b", y.tag, V, y.v);
    end
    assert (B === y.b) else begin
      miscompares++;
      $error("FAIL %s B got %0d exp %0d", y.tag, B, y.b);
    end
    assert (O === y.o) else begin
      miscompares++;
      $error("FAIL %s O got %b exp %b", y.tag, O, y.o);
    end
    assert (P === y.p) else begin
      miscompares++;
      $error("FAIL %s P got %0d exp %0d", y.tag, P, y.p);
    end
  endtask

  initial begin
    step("rst0", 1, 32'h0, 1, 0, 0, 0, 0, 0);
    step("rst1", 1, 32'h0, 1, 0, 0, 0, 0, 0);

    step("single", 0, 32'h0000_0100, 1, 0, 8, 1, 0, 1);
    for (int i = 0; i < 5; i++)
      step("hold8", 0, 32'h0, 1, 0, 8, 1, 0, 1);
    step("ack8", 0, 32'h0, 1, 1, 0, 0, 0, 0);

    step("pri2", 0, 32'h8000_0004, 1, 0, 2, 1, 0, 2);
    step("stall", 0, 32'h0000_0001, 1, 0, 2, 1, 0, 3);
    step("drain0", 0, 32'h0, 1, 1, 0, 1, 0, 2);
    step("drain31", 0, 32'h0, 1, 1, 31, 1, 0, 1);
    step("empty", 0, 32'h0, 1, 1, 0, 0, 0, 0);

    step("pres5", 0, 32'h0000_0020, 1, 0, 5, 1, 0, 1);
    step("ovf5", 0, 32'h0000_0020, 1, 0, 5, 1, 1, 1);
    step("rstmid", 1, 32'h0000_0008, 1, 1, 0, 0, 0, 0);

    step("pres5b", 0, 32'h0000_0020, 1, 0, 5, 1, 0, 1);
    step("collide", 0, 32'h0000_0020, 1, 1, 5, 1, 0, 1);
    step("ack5", 0, 32'h0, 1, 1, 0, 0, 0, 0);

    step("mask", 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
    step("full", 0, 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 32);
    step("fullovf", 0, 32'h0000_0001, 1, 0, 0, 1, 1, 32);
    for (int i = 0; i < 31; i++)
      step("drainall", 0, 32'hFFFF_FFFF, 0, 1,
           5'(i + 1), 1, 1, 6'(31 - i));
    step("drainend", 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 1, 0);
    step("idleack", 0, 32'h0, 1, 1, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
